uart_rx_buffer: RTL and testbench

- Serial receive front end feeding the core's memory-mapped UART read port (uart_empty / uart_in / uart_rdreq).
- Deserializes 8N1 frames from the rxd pin into bytes and buffers them in a small synchronous FIFO.
- The core pops bytes whenever a load hits the UART address.
- Framing and overrun errors are reported on sticky flags for the seg7/debug path.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_buffer_if.sv | 12 +
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_rx_buffer.sv | 147 ++++++++++++++
 tb/tb_uart_rx_buffer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, frame width
// and the default bit period.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int FRAME_BITS           = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Core-side UART read port: pop request in, show-ahead head byte and empty out.
interface uart_rx_buffer_if;
    import uart_pkg::*;

    logic                  uart_rdreq;
    logic                  uart_empty;
    logic [FRAME_BITS-1:0] uart_in;

    modport master (output uart_rdreq, input uart_empty, input uart_in);
    modport slave  (input uart_rdreq, output uart_empty, output uart_in);

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; storage is not reset, the head reads as zero when empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(do_pop);
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(do_push);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// 8N1 serial receiver with a show-ahead byte FIFO and sticky framing/overrun flags.
//
// state    | meaning
// ST_IDLE  | line idle, waiting for a falling edge on rxd_s
// ST_START | half-bit wait, then confirm the start bit is still low
// ST_DATA  | sample 8 data bits LSB first, one bit period apart
// ST_STOP  | sample the stop bit; high pushes the byte, low is a framing error
// ST_BREAK | line held low after a bad stop bit; wait for it to return high
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    input  logic              err_clr,
    output logic              overrun,
    output logic              frame_err,
    uart_rx_buffer_if.slave   bus
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_LOAD  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(FRAME_BITS - 1);

    rx_state_e             state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            idx_q, idx_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  push_q, push_d;
    logic                  rxd_meta_q, rxd_s_q;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;
    logic                  frame_event;
    logic                  baud_zero;
    logic                  fifo_empty, fifo_full, pop_ok;

    assign baud_zero = (baud_q == '0);
    assign pop_ok    = bus.uart_rdreq && !fifo_empty;

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        frame_event = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxd_s_q) begin
                    baud_d  = HALF_LOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!baud_zero) begin
                    baud_d = baud_q - 1'b1;
                end else if (!rxd_s_q) begin
                    baud_d  = BIT_LOAD;
                    idx_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!baud_zero) begin
                    baud_d = baud_q - 1'b1;
                end else begin
                    shift_d[idx_q] = rxd_s_q;
                    baud_d         = BIT_LOAD;
                    if (idx_q == LAST_BIT) state_d = ST_STOP;
                    else                   idx_d   = idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (!baud_zero) begin
                    baud_d = baud_q - 1'b1;
                end else if (rxd_s_q) begin
                    push_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    frame_event = 1'b1;
                    state_d     = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rxd_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A new error in the same cycle as err_clr must leave the flag set.
    always_comb begin
        overrun_d   = err_clr ? 1'b0 : overrun_q;
        frame_err_d = err_clr ? 1'b0 : frame_err_q;
        if (push_q && fifo_full && !pop_ok) overrun_d   = 1'b1;
        if (frame_event)                    frame_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            state_q     <= ST_IDLE;
            baud_q      <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd;
            rxd_s_q     <= rxd_meta_q;
            state_q     <= state_d;
            baud_q      <= baud_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH      (FRAME_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (shift_q),
        .pop       (bus.uart_rdreq),
        .pop_data  (bus.uart_in),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.uart_empty = fifo_empty;
    assign overrun        = overrun_q;
    assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer with a 16-clock bit period and a 4-entry FIFO.
module tb_uart_rx_buffer;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst, rxd, err_clr;
    logic overrun, frame_err;
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;
    int   fall_cyc = 0;
    int   t0     = 0;
    logic prev_empty = 1'b1;

    uart_rx_buffer_if bus ();

    uart_rx_buffer #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .err_clr   (err_clr),
        .overrun   (overrun),
        .frame_err (frame_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prev_empty === 1'b1 && bus.uart_empty === 1'b0) fall_cyc <= cyc;
        prev_empty <= bus.uart_empty;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(posedge clk);
        #1;
        t0  = cyc;
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = d[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rxd = stop;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        @(posedge clk);
        #1 bus.uart_rdreq = 1'b1;
        @(posedge clk);
        #1 bus.uart_rdreq = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; err_clr = 1'b0; bus.uart_rdreq = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_empty", bus.uart_empty, 1);
        chk("rst_in", bus.uart_in, 8'h00);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", frame_err, 0);

        // single frame
        idle(3);
        send_frame(8'hA5, 1'b1);
        idle(4);
        @(negedge clk);
        chk("single_latency", (fall_cyc >= t0) && (fall_cyc - t0 <= 156), 1);
        chk("single_empty", bus.uart_empty, 0);
        chk("single_data", bus.uart_in, 8'hA5);
        pop_one();
        @(negedge clk);
        chk("single_pop_empty", bus.uart_empty, 1);
        chk("single_pop_in", bus.uart_in, 8'h00);

        // glitch rejection
        idle(5);
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(30);
        @(negedge clk);
        chk("glitch_state", dut.state_q, ST_IDLE);
        chk("glitch_empty", bus.uart_empty, 1);
        chk("glitch_frame_err", frame_err, 0);

        // framing error then recovery
        send_frame(8'h3C, 1'b0);
        idle(40);
        rxd = 1'b1;
        idle(10);
        @(negedge clk);
        chk("ferr_flag", frame_err, 1);
        chk("ferr_dropped", bus.uart_empty, 1);
        chk("ferr_state", dut.state_q, ST_IDLE);
        send_frame(8'h11, 1'b1);
        idle(4);
        @(negedge clk);
        chk("ferr_next_data", bus.uart_in, 8'h11);
        pop_one();
        @(negedge clk);
        chk("ferr_only_one", bus.uart_empty, 1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("ferr_clear", frame_err, 0);

        // overrun: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            idle(2);
            @(negedge clk);
            if (i == 4) chk("ovr_not_yet", overrun, 0);
        end
        chk("ovr_flag", overrun, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("ovr_pop%0d", k), bus.uart_in, 32'(k));
            pop_one();
        end
        @(negedge clk);
        chk("ovr_drained", bus.uart_empty, 1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("ovr_clear", overrun, 0);

        // full FIFO with a pop on the push cycle of the fifth byte
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b1);
            idle(2);
        end
        fork
            send_frame(8'h55, 1'b1);
            begin
                @(posedge clk);
                repeat (155) @(posedge clk);
                #1 bus.uart_rdreq = 1'b1;
                @(posedge clk);
                #1 bus.uart_rdreq = 1'b0;
            end
        join
        idle(4);
        @(negedge clk);
        chk("fullpop_overrun", overrun, 0);
        begin
            logic [7:0] exp_bytes [4];
            exp_bytes[0] = 8'h02; exp_bytes[1] = 8'h03;
            exp_bytes[2] = 8'h04; exp_bytes[3] = 8'h55;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk($sformatf("fullpop_b%0d", k), bus.uart_in, 32'(exp_bytes[k]));
                pop_one();
            end
        end
        @(negedge clk);
        chk("fullpop_drained", bus.uart_empty, 1);

        // reset during data bit 3 of 0xFF
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (CPB * 3 + 8) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_state", dut.state_q, ST_IDLE);
        chk("midrst_empty", bus.uart_empty, 1);
        idle(20);
        send_frame(8'h42, 1'b1);
        idle(4);
        @(negedge clk);
        chk("midrst_data", bus.uart_in, 8'h42);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_frame_err", frame_err, 0);
        pop_one();
        @(negedge clk);
        chk("midrst_only_one", bus.uart_empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
